// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_pkg
// Brief   : Shared types and constants for the UART transmit path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
//------------------------------------------------------------------------------
// Module  : uart_baud_counter
// Brief   : Free-running bit-period counter; bit_tick pulses on the last cycle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic bit_tick
);

    localparam int                c_cnt_w      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last_count = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (restart) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == c_last_count) ? '0 : r_count + 1'b1;
        end
    end

    assign bit_tick = enable && !restart && (r_count == c_last_count);

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_serializer
// Brief   : One-byte buffered 8N1 UART transmitter with optional even parity.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] w_data,
    input  logic                 wr_uart,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_idle,
    output logic                 tx_done,
    output logic                 overrun
);

    localparam int                   c_bit_cnt_w = $clog2(DATA_BITS);
    localparam logic [c_bit_cnt_w-1:0] c_last_data = c_bit_cnt_w'(DATA_BITS - 1);
    localparam logic [c_bit_cnt_w-1:0] c_last_stop = c_bit_cnt_w'(STOP_BITS - 1);

    tx_state_t              r_state, w_state_next;
    logic [DATA_BITS-1:0]   r_hold, r_shift;
    logic                   r_hold_full, w_hold_full_next;
    logic                   r_parity, r_tx_idle, r_overrun;
    logic [c_bit_cnt_w-1:0] r_bit_cnt, w_bit_cnt_next;
    logic                   w_bit_tick, w_restart, w_load, w_accept, w_done;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .restart  (w_restart),
        .enable   (r_state != IDLE),
        .bit_tick (w_bit_tick)
    );

    assign w_accept         = wr_uart && !r_hold_full;
    assign w_hold_full_next = w_accept ? 1'b1 : (w_load ? 1'b0 : r_hold_full);

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_load         = 1'b0;
        w_restart      = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_restart    = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == c_last_data) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_tick) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = STOP;
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == c_last_stop) begin
                        // Back-to-back frames: the baud counter wraps to 0 on its own here
                        w_done         = 1'b1;
                        w_bit_cnt_next = '0;
                        if (r_hold_full) begin
                            w_load       = 1'b1;
                            w_state_next = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tx_idle   <= 1'b1;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_hold_full <= w_hold_full_next;
            r_tx_idle   <= (w_state_next == IDLE) && !w_hold_full_next;
            r_overrun   <= wr_uart && r_hold_full;
            if (w_accept) begin
                r_hold <= w_data;
            end
            if (w_load) begin
                r_shift  <= r_hold;
                r_parity <= ^r_hold;
            end else if (r_state == DATA && w_bit_tick) begin
                r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            START:   tx = 1'b0;
            DATA:    tx = r_shift[0];
            PARITY:  tx = r_parity;
            default: tx = 1'b1;
        endcase
    end

    assign tx_busy = r_hold_full;
    assign tx_idle = r_tx_idle;
    assign tx_done = w_done;
    assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_tx_serializer
// Brief   : Bench for uart_tx_serializer: 8N1 and 8E2 instances, frame model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr      [2];
    logic [7:0] wd      [2];
    logic       tx_o    [2];
    logic       busy_o  [2];
    logic       idle_o  [2];
    logic       done_o  [2];
    logic       ovr_o   [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    always #5 clock = ~clock;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clock(clock), .reset(reset), .w_data(wd[0]), .wr_uart(wr[0]),
        .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_idle(idle_o[0]),
        .tx_done(done_o[0]), .overrun(ovr_o[0])
    );

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clock(clock), .reset(reset), .w_data(wd[1]), .wr_uart(wr[1]),
        .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_idle(idle_o[1]),
        .tx_done(done_o[1]), .overrun(ovr_o[1])
    );

    // Reference model: a byte slot, the frame in flight and its elapsed cycle count
    logic       m_hold_v [2];
    logic [7:0] m_hold_b [2];
    logic       m_active [2];
    logic [7:0] m_byte   [2];
    int         m_pos    [2];
    logic       m_ovr    [2];

    function automatic int flen(int i);
        return (i == 1) ? (10 + 1 + 2 - 1) * CPB : (10 + 0 + 1 - 1) * CPB;
    endfunction

    function automatic logic frame_bit(int i, logic [7:0] b, int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && i == 1) return ^b;
        return 1'b1;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_hold_v[i] <= 1'b0; m_hold_b[i] <= '0; m_active[i] <= 1'b0;
                m_byte[i]   <= '0;   m_pos[i]    <= 0;  m_ovr[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_ovr[i] <= wr[i] && m_hold_v[i];
                if (wr[i] && !m_hold_v[i]) begin
                    m_hold_v[i] <= 1'b1;
                    m_hold_b[i] <= wd[i];
                end
                if (m_active[i] && m_pos[i] != flen(i) - 1) begin
                    m_pos[i] <= m_pos[i] + 1;
                end else if (m_hold_v[i]) begin
                    m_active[i] <= 1'b1;
                    m_pos[i]    <= 0;
                    m_byte[i]   <= m_hold_b[i];
                    m_hold_v[i] <= 1'b0;
                end else begin
                    m_active[i] <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic write(input int i, input logic [7:0] b);
        wr[i] = 1'b1;
        wd[i] = b;
        @(posedge clock); #2;
        wr[i] = 1'b0;
    endtask

    typedef struct {
        int          cfg;
        logic [7:0]  data;
        logic [11:0] bits;   // frame bits, index 0 = start bit
        int          nbits;
    } frame_vec_t;

    frame_vec_t tbl [6];

    task automatic run_frame(input int idx);
        int ndone;
        int dcyc;
        int i;
        ndone = 0;
        dcyc  = -1;
        i     = tbl[idx].cfg;
        write(i, tbl[idx].data);
        @(posedge clock);
        for (int c = 1; c <= tbl[idx].nbits * CPB; c++) begin
            @(negedge clock);
            check($sformatf("frame%0d_tx_c%0d", idx, c), tx_o[i], tbl[idx].bits[(c-1)/CPB]);
            if (done_o[i]) begin
                ndone++;
                dcyc = c;
            end
        end
        check_int($sformatf("frame%0d_done_count", idx), ndone, 1);
        check_int($sformatf("frame%0d_done_cycle", idx), dcyc, tbl[idx].nbits * CPB);
        @(negedge clock);
        check($sformatf("frame%0d_idle_after", idx), idle_o[i], 1'b1);
        @(posedge clock); #2;
    endtask

    initial begin
        int   cnt;
        int   lowc;
        int   ovc;
        int   idlc;
        int   dq[$];
        logic [7:0] rx;

        tbl[0] = '{cfg: 0, data: 8'hA5, bits: 12'b00_1_1010_0101_0, nbits: 10};
        tbl[1] = '{cfg: 0, data: 8'h3C, bits: 12'b00_1_0011_1100_0, nbits: 10};
        tbl[2] = '{cfg: 1, data: 8'h07, bits: 12'b11_1_0000_0111_0, nbits: 12};
        tbl[3] = '{cfg: 1, data: 8'h03, bits: 12'b11_0_0000_0011_0, nbits: 12};
        tbl[4] = '{cfg: 0, data: 8'hFF, bits: 12'b00_1_1111_1111_0, nbits: 10};
        tbl[5] = '{cfg: 1, data: 8'h80, bits: 12'b11_1_1000_0000_0, nbits: 12};

        for (int i = 0; i < 2; i++) begin
            wr[i] = 1'b0;
            wd[i] = '0;
        end

        fork
            forever begin
                @(negedge clock);
                if (mon_en) begin
                    for (int i = 0; i < 2; i++) begin
                        check($sformatf("mon%0d_tx", i), tx_o[i],
                              m_active[i] ? frame_bit(i, m_byte[i], m_pos[i] / CPB) : 1'b1);
                        check($sformatf("mon%0d_busy", i), busy_o[i], m_hold_v[i]);
                        check($sformatf("mon%0d_idle", i), idle_o[i], !m_active[i] && !m_hold_v[i]);
                        check($sformatf("mon%0d_done", i), done_o[i],
                              m_active[i] && m_pos[i] == flen(i) - 1);
                        check($sformatf("mon%0d_overrun", i), ovr_o[i], m_ovr[i]);
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_tx", i), tx_o[i], 1'b1);
            check($sformatf("rst%0d_busy", i), busy_o[i], 1'b0);
            check($sformatf("rst%0d_idle", i), idle_o[i], 1'b1);
            check($sformatf("rst%0d_done", i), done_o[i], 1'b0);
            check($sformatf("rst%0d_overrun", i), ovr_o[i], 1'b0);
        end
        mon_en = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;

        // Quiet line for 1000 cycles
        lowc = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++)
                if (!tx_o[i] || done_o[i] || ovr_o[i]) lowc++;
        end
        check_int("quiet_events", lowc, 0);
        @(posedge clock); #2;

        // Single frames from the vector table
        for (int k = 0; k < 6; k++) run_frame(k);

        // Back-to-back frames: second write right after tx_busy falls
        write(0, 8'h3C);
        @(posedge clock); #2;
        check("b2b_busy_fell", busy_o[0], 1'b0);
        write(0, 8'hC3);
        idlc = 0;
        for (int c = 2; c <= 100; c++) begin
            @(negedge clock);
            if (done_o[0]) dq.push_back(c);
            if (c <= 80 && idle_o[0]) idlc++;
            if (c == 41) check("b2b_second_start", tx_o[0], 1'b0);
        end
        check_int("b2b_done_count", dq.size(), 2);
        if (dq.size() == 2) begin
            check_int("b2b_done0", dq[0], 40);
            check_int("b2b_done1", dq[1], 80);
        end
        check_int("b2b_idle_gap", idlc, 0);
        @(posedge clock); #2;

        // Write while busy is dropped with overrun
        write(0, 8'h11);
        write(0, 8'h22);
        ovc  = 0;
        lowc = 0;
        rx   = '0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (ovr_o[0]) ovc++;
            if (c % CPB == 2 && (c - 2) / CPB >= 1 && (c - 2) / CPB <= 8)
                rx[(c - 2) / CPB - 1] = tx_o[0];
            if (c > 40 && !tx_o[0]) lowc++;
        end
        check_int("ovr_count", ovc, 1);
        check_int("ovr_rx_byte", int'(rx), 8'h11);
        check_int("ovr_no_second_frame", lowc, 0);
        @(posedge clock); #2;

        // Reset in the middle of data bit 3
        write(0, 8'h00);
        @(posedge clock);
        repeat (17) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_tx", tx_o[0], 1'b1);
        check("midrst_busy", busy_o[0], 1'b0);
        check("midrst_idle", idle_o[0], 1'b1);
        @(posedge clock); #2;
        reset = 1'b0;
        run_frame(4);

        // Randomized traffic on both instances, checked by the model
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                wr[i] = ($urandom_range(0, 3) == 0);
                wd[i] = 8'($urandom);
            end
            @(posedge clock); #2;
        end
        wr[0] = 1'b0;
        wr[1] = 1'b0;
        cnt = 0;
        repeat (200) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++) if (idle_o[i]) cnt++;
        check_int("final_idle", cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
